// File: rtl/regfile.sv
// 32 x DATA_WIDTH register file: two combinational read ports, one
// synchronous write port, r0 hardwired to zero, synchronous active-high
// reset that clears every register and wins over a same-cycle write.
module regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite,
    input  logic [4:0]            ra1,
    input  logic [4:0]            ra2,
    input  logic [4:0]            wa,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    // r0 has no storage; entries 1..31 only.
    logic [DATA_WIDTH-1:0] regs_q [1:31];
    logic [DATA_WIDTH-1:0] regs_d [1:31];

    // Next-state: hold everything, then overlay the single write (never r0).
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (regwrite && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    // State update: reset clears all registers and takes priority over writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: no bypass from wd, so a same-cycle write shows the old value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) begin
            rd1 = regs_q[ra1];
        end
        if (ra2 != 5'd0) begin
            rd2 = regs_q[ra2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read on both ports, r0,
// write enable, no-bypass timing and reset priority.
module tb_regfile;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          regwrite;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [4:0]    wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    int total;
    int bad;

    regfile #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .regwrite (regwrite),
        .ra1      (ra1),
        .ra2      (ra2),
        .wa       (wa),
        .wd       (wd),
        .rd1      (rd1),
        .rd2      (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        regwrite = 1'b0;
        ra1      = 5'd0;
        ra2      = 5'd0;
        wa       = 5'd0;
        wd       = '0;

        // r0 reads zero even before any reset
        #1;
        check("r0_prereset_rd1", rd1, 32'h0);
        check("r0_prereset_rd2", rd2, 32'h0);

        // reset for one edge, then sweep every address on both ports
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_r%0d", i), rd1, 32'h0);
            check($sformatf("reset_rd2_r%0d", 31 - i), rd2, 32'h0);
        end

        // write r3 = 0x14
        regwrite = 1'b1;
        wa       = 5'd3;
        wd       = 32'h14;
        tick();

        // read r3 while writing r4 = 0x1D
        ra1 = 5'd3;
        wa  = 5'd4;
        wd  = 32'h1D;
        #1;
        check("rd1_r3", rd1, 32'h14);
        tick();
        check("rd1_r3_hold", rd1, 32'h14);

        // port 2, then both ports on the same register
        ra2 = 5'd4;
        #1;
        check("rd2_r4", rd2, 32'h1D);
        ra1 = 5'd4;
        #1;
        check("both_rd1_r4", rd1, 32'h1D);
        check("both_rd2_r4", rd2, 32'h1D);

        // write to r0 is ignored
        wa = 5'd0;
        wd = 32'hFFFF_FFFF;
        tick();
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        check("r0_write_rd1", rd1, 32'h0);
        check("r0_write_rd2", rd2, 32'h0);

        // regwrite=0 leaves r3 untouched
        regwrite = 1'b0;
        wa       = 5'd3;
        wd       = 32'hDEAD_BEEF;
        tick();
        ra1 = 5'd3;
        ra2 = 5'd4;
        #1;
        check("we0_r3", rd1, 32'h14);
        check("we0_r4", rd2, 32'h1D);

        // no bypass: same-cycle read of the write address shows old r5
        regwrite = 1'b1;
        ra1      = 5'd5;
        wa       = 5'd5;
        wd       = 32'hA5A5_A5A5;
        #1;
        check("nobypass_before", rd1, 32'h0);
        tick();
        check("nobypass_after", rd1, 32'hA5A5_A5A5);

        // full width stored in the top register
        wa = 5'd31;
        wd = 32'h8000_0001;
        tick();
        regwrite = 1'b0;
        ra2      = 5'd31;
        #1;
        check("fullwidth_r31", rd2, 32'h8000_0001);
        check("r5_kept", rd1, 32'hA5A5_A5A5);

        // reset beats a same-cycle write
        reset    = 1'b1;
        regwrite = 1'b1;
        wa       = 5'd7;
        wd       = 32'h1234;
        tick();
        reset    = 1'b0;
        regwrite = 1'b0;
        ra1      = 5'd7;
        ra2      = 5'd3;
        #1;
        check("rstprio_r7", rd1, 32'h0);
        check("rstprio_r3", rd2, 32'h0);
        ra1 = 5'd5;
        ra2 = 5'd31;
        #1;
        check("rstprio_r5", rd1, 32'h0);
        check("rstprio_r31", rd2, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (ra1/ra2/wa fields) and the ALU/writeback path.

Parameters:
- DATA_WIDTH, 32, width in bits of each register and of the wd/rd1/rd2 data ports.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all registers on the rising clk edge while high
- regwrite  input  1  write enable for the write port
- ra1  input  5  read address, port 1
- ra2  input  5  read address, port 2
- wa  input  5  write address
- wd  input  DATA_WIDTH  write data
- rd1  output  DATA_WIDTH  read data, port 1
- rd2  output  DATA_WIDTH  read data, port 2

Behaviour:
- Storage: 32 registers × DATA_WIDTH bits, indexed 0..31 by 5-bit addresses. All 32 addresses are valid; there is no out-of-range case.
- Reset: synchronous and active-high. On a rising clk edge with reset=1, all registers become 0. Reset has priority over any write in the same cycle. Once the edge has occurred, rd1/rd2 read 0 for every address.
- Before the first reset, register contents other than r0 are undefined. r0 always reads 0, including before any reset.
- Write: on a rising clk edge with reset=0, regwrite=1 and wa!=0, reg[wa] <= wd. With regwrite=0, no register changes.
- Write to r0 (wa=0) is silently ignored; r0 stays 0.
- Read: purely combinational, zero latency.
  - rd1 = (ra1==0) ? 0 : reg[ra1]
  - rd2 = (ra2==0) ? 0 : reg[ra2]
  - Outputs track address changes within the same cycle.
- Write-then-read timing: a value written at edge N is visible on rd1/rd2 immediately after edge N, i.e. throughout cycle N+1.
- No internal bypass: during the cycle before the edge, reading the address being written returns the old contents, not wd.
- Both read ports may address the same register simultaneously, or the register being written; each port returns reg contents independently.
- Full data width is stored; no truncation or sign handling.

Test Plan:
- Reset: assert reset for 1 edge, then read ra1=0..31 and ra2=31..0 -> all reads 0x00000000.
- Write/read port 1: regwrite=1, wa=3, wd=0x14, clock. Next cycle set ra1=3, wa=4, wd=0x1D, clock -> rd1=0x14 while r3 is held; after the edge, r4=0x1D.
- Read port 2: ra2=4 after the previous sequence -> rd2=0x1D. With ra1=ra2=4, both ports show 0x1D.
- r0 hardwired: regwrite=1, wa=0, wd=0xFFFFFFFF, clock -> rd1 (ra1=0) = 0 and rd2 (ra2=0) = 0.
- Write enable/no bypass:
  - regwrite=0, wa=3, wd=0xDEADBEEF, clock -> rd1 (ra1=3) still 0x14.
  - regwrite=1 with ra1=wa=5, wd=0xA5A5A5A5 -> rd1 shows old r5 before the edge and 0xA5A5A5A5 after.
- Reset priority: reset=1, regwrite=1, wa=7, wd=0x1234, clock -> r7 reads 0. A previously written r3 also reads 0.
